led_sequencer: RTL and testbench

Multi-channel LED pattern generator and parametrised successor of the single-pattern blinker. It drives `CHANNELS` independent LED outputs. Each channel is runtime-configurable through a valid/ready write port as OFF, ON, BLINK (programmable on/off durations) or ONESHOT. All timing derives from one shared, free-running millisecond-class tick. The block sits between the board-level control logic (UART/register front-end) and the LED pins.

---
 rtl/led_seq_pkg.sv | 18 +
 rtl/led_tick_gen.sv | 33 +++
 rtl/led_sequencer.sv | 133 +++++++++++++
 tb/tb_led_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared encodings and helpers for the LED sequencer
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } led_mode_t;

   localparam logic PH_ON  = 1'b0;
   localparam logic PH_OFF = 1'b1;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - shared free-running prescaler, one-cycle tick every CLK_FREQ/TICK_HZ clocks
module led_tick_gen #(
   parameter int CLK_FREQ = 25_000_000,
   parameter int TICK_HZ  = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int P  = CLK_FREQ / TICK_HZ;
   localparam int PW = (P > 1) ? $clog2(P) : 1;
   localparam logic [PW-1:0] LAST = PW'(P - 1);

   if (P < 2) begin : g_bad_prescale
      $error("led_tick_gen: CLK_FREQ/TICK_HZ must be at least 2");
   end

   logic [PW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + PW'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - multi-channel LED pattern generator (OFF/ON/BLINK/ONESHOT)
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int  CLK_FREQ = 25_000_000,
   parameter int  TICK_HZ  = 1000,
   parameter int  CHANNELS = 8,
   parameter int  TIME_W   = 16,
   localparam int CH_W     = ch_width(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [TIME_W-1:0]   cfg_on,
   input  logic [TIME_W-1:0]   cfg_off,
   input  logic                sync_restart,
   output logic [CHANNELS-1:0] leds,
   output logic [CHANNELS-1:0] oneshot_done
);

   localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

   if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
      $error("led_sequencer: CHANNELS must be 1..32");
   end

   logic tick;
   logic accept;

   assign cfg_ready = ~rst;
   assign accept    = cfg_valid & cfg_ready;

   led_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .TICK_HZ  (TICK_HZ)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (sync_restart),
      .tick  (tick)
   );

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      led_mode_t         mode, mode_n;
      logic              phase, phase_n;
      logic [TIME_W-1:0] on_t, off_t, on_n, off_n;
      logic [TIME_W-1:0] cnt, cnt_n;
      logic              hit, end_on, end_off;
      logic              led_n, done_n, led_q, done_q;

      // Out-of-range channel numbers match no iteration, so such writes vanish.
      assign hit     = accept && (cfg_ch == CH_W'(i));
      assign end_on  = (on_t == '0) || (cnt == on_t - ONE);
      assign end_off = (off_t == '0) || (cnt == off_t - ONE);
      assign on_n    = hit ? cfg_on : on_t;
      assign off_n   = hit ? cfg_off : off_t;

      always_comb begin
         mode_n  = mode;
         phase_n = phase;
         cnt_n   = cnt;
         done_n  = 1'b0;
         if (hit) begin
            cnt_n   = '0;
            phase_n = PH_ON;
            // A zero-length oneshot completes immediately on acceptance.
            if (led_mode_t'(cfg_mode) == MODE_ONESHOT && cfg_on == '0) begin
               mode_n = MODE_OFF;
               done_n = 1'b1;
            end else begin
               mode_n = led_mode_t'(cfg_mode);
            end
         end else if (mode == MODE_BLINK) begin
            if (sync_restart) begin
               cnt_n   = '0;
               phase_n = PH_ON;
            end else if (tick) begin
               if ((phase == PH_ON) ? end_on : end_off) begin
                  cnt_n   = '0;
                  phase_n = ~phase;
               end else begin
                  cnt_n = cnt + ONE;
               end
            end
         end else if (mode == MODE_ONESHOT && tick) begin
            if (end_on) begin
               mode_n = MODE_OFF;
               cnt_n  = '0;
               done_n = 1'b1;
            end else begin
               cnt_n = cnt + ONE;
            end
         end
      end

      always_comb begin
         led_n = 1'b0;
         case (mode_n)
            MODE_ON:      led_n = 1'b1;
            MODE_BLINK:   led_n = (on_n != '0) && (phase_n == PH_ON || off_n == '0);
            MODE_ONESHOT: led_n = 1'b1;
            default:      led_n = 1'b0;
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mode   <= MODE_OFF;
            phase  <= PH_ON;
            on_t   <= '0;
            off_t  <= '0;
            cnt    <= '0;
            led_q  <= 1'b0;
            done_q <= 1'b0;
         end else begin
            mode   <= mode_n;
            phase  <= phase_n;
            on_t   <= on_n;
            off_t  <= off_n;
            cnt    <= cnt_n;
            led_q  <= led_n;
            done_q <= done_n;
         end
      end

      assign leds[i]         = led_q;
      assign oneshot_done[i] = done_q;
   end

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for led_sequencer (P=10, 4 channels plus a 3-channel copy)
module tb_led_sequencer;

   localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_ONESHOT = 2'd3;

   logic       clk, rst;
   logic       cfg_valid, cfg_valid3, cfg_ready, cfg_ready3, sync_restart;
   logic [1:0] cfg_ch, cfg_mode;
   logic [7:0] cfg_on, cfg_off;
   logic [3:0] leds, oneshot_done;
   logic [2:0] leds3, oneshot_done3;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   typedef struct {
      int         cyc;
      string      nm;
      logic [3:0] lm, lv, dm, dv;
      logic [2:0] m3, v3;
      logic       rc, rv;
   } exp_t;

   exp_t sb[$];

   led_sequencer #(.CLK_FREQ(1000), .TICK_HZ(100), .CHANNELS(4), .TIME_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
      .sync_restart(sync_restart), .leds(leds), .oneshot_done(oneshot_done));

   led_sequencer #(.CLK_FREQ(1000), .TICK_HZ(100), .CHANNELS(3), .TIME_W(8)) dut3 (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
      .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
      .sync_restart(sync_restart), .leds(leds3), .oneshot_done(oneshot_done3));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
      $fatal(1, "watchdog");
   end

   function automatic void push(input int c, input string nm, input logic [3:0] lm, input logic [3:0] lv,
                                input logic [3:0] dm, input logic [3:0] dv, input logic [2:0] m3,
                                input logic [2:0] v3, input logic rc, input logic rv);
      exp_t e;
      int   i;
      e.cyc = c; e.nm = nm; e.lm = lm; e.lv = lv; e.dm = dm; e.dv = dv;
      e.m3 = m3; e.v3 = v3; e.rc = rc; e.rv = rv;
      i = sb.size();
      while (i > 0 && sb[i-1].cyc > c) i--;
      sb.insert(i, e);
   endfunction

   function automatic void exp_l(input int c, input string nm, input logic [3:0] lm, input logic [3:0] lv,
                                 input logic [3:0] dm, input logic [3:0] dv);
      push(c, nm, lm, lv, dm, dv, 3'b000, 3'b000, 1'b0, 1'b0);
   endfunction

   // Monitor: compares every queued expectation at the falling edge of its cycle.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_cmp++;
         if (e.cyc != cyc || ((leds ^ e.lv) & e.lm) != 4'b0 || ((oneshot_done ^ e.dv) & e.dm) != 4'b0 ||
             ((leds3 ^ e.v3) & e.m3) != 3'b0 || (e.m3 != 3'b0 && oneshot_done3 != 3'b0) ||
             (e.rc && (cfg_ready != e.rv || cfg_ready3 != e.rv))) begin
            n_bad++;
            $display("FAIL %s @%0d (due %0d): leds=%b done=%b leds3=%b done3=%b rdy=%b; required leds=%b/m%b done=%b/m%b leds3=%b/m%b rdy=%b/chk%b",
                     e.nm, cyc, e.cyc, leds, oneshot_done, leds3, oneshot_done3, cfg_ready,
                     e.lv, e.lm, e.dv, e.dm, e.v3, e.m3, e.rv, e.rc);
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_write(input int tgt, input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] on,
                           input logic [7:0] off, input logic rs, output int k);
      cfg_ch = ch; cfg_mode = mode; cfg_on = on; cfg_off = off;
      cfg_valid = (tgt == 0); cfg_valid3 = (tgt == 1); sync_restart = rs;
      @(posedge clk);
      #2;
      k = cyc;
      cfg_valid = 1'b0; cfg_valid3 = 1'b0; sync_restart = 1'b0;
   endtask

   task automatic do_restart(output int k);
      sync_restart = 1'b1;
      @(posedge clk);
      #2;
      k = cyc;
      sync_restart = 1'b0;
   endtask

   initial begin
      int k, k2, k3, r, w, c0;
      rst = 1'b1; cfg_valid = 1'b0; cfg_valid3 = 1'b0; sync_restart = 1'b0;
      cfg_ch = '0; cfg_mode = '0; cfg_on = '0; cfg_off = '0;
      repeat (2) @(posedge clk);
      #2;
      push(cyc, "reset_state", 4'hF, 4'h0, 4'hF, 4'h0, 3'h7, 3'h0, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      c0 = cyc;
      for (int j = 0; j < 100; j++)
         push(c0 + j, "idle_after_reset", 4'hF, 4'h0, 4'hF, 4'h0, 3'h7, 3'h0, 1'b1, 1'b1);
      wait_until(c0 + 100);

      // BLINK ch0 on=2 off=3, then phase-align: 20 high / 30 low, period 50.
      do_write(0, 2'd0, M_BLINK, 8'd2, 8'd3, 1'b0, k);
      exp_l(k, "blink_write_latency", 4'b0001, 4'b0001, 4'h0, 4'h0);
      do_restart(r);
      for (int j = 0; j < 160; j++)
         exp_l(r + j, "blink_2_3", 4'b0001, ((j % 50) < 20) ? 4'b0001 : 4'b0000, 4'h0, 4'h0);
      wait_until(r + 160);

      // ONESHOT ch3 on=4 aligned to the tick grid: 40 cycles high, done with the fall.
      do_write(0, 2'd3, M_ONESHOT, 8'd4, 8'd0, 1'b1, w);
      for (int j = 0; j < 40; j++)
         exp_l(w + j, "oneshot_high", 4'b1000, 4'b1000, 4'b1000, 4'b0000);
      exp_l(w + 40, "oneshot_fall_done", 4'b1000, 4'b0000, 4'b1000, 4'b1000);
      for (int j = 41; j < 61; j++)
         exp_l(w + j, "oneshot_then_off", 4'b1000, 4'b0000, 4'b1000, 4'b0000);
      wait_until(w + 61);

      // Zero durations on ch1.
      do_write(0, 2'd1, M_BLINK, 8'd0, 8'd5, 1'b0, k);
      for (int j = 0; j < 80; j++)
         exp_l(k + j, "blink_on0", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
      wait_until(k + 80);
      do_write(0, 2'd1, M_BLINK, 8'd5, 8'd0, 1'b0, k2);
      for (int j = 0; j < 100; j++)
         exp_l(k2 + j, "blink_off0", 4'b0010, 4'b0010, 4'b0010, 4'b0000);
      wait_until(k2 + 100);
      do_write(0, 2'd1, M_ONESHOT, 8'd0, 8'd0, 1'b0, k3);
      exp_l(k3, "oneshot_on0_done", 4'b0010, 4'b0000, 4'b0010, 4'b0010);
      for (int j = 1; j < 21; j++)
         exp_l(k3 + j, "oneshot_on0_after", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
      wait_until(k3 + 21);

      // Out-of-range write on the 3-channel copy changes nothing.
      do_write(1, 2'd0, M_ON, 8'd0, 8'd0, 1'b0, k);
      push(k, "dut3_ch0_on", 4'h0, 4'h0, 4'h0, 4'h0, 3'h7, 3'b001, 1'b0, 1'b0);
      do_write(1, 2'd3, M_OFF, 8'd0, 8'd0, 1'b0, k2);
      for (int j = 0; j < 30; j++)
         push(k2 + j, "out_of_range", 4'h0, 4'h0, 4'h0, 4'h0, 3'h7, 3'b001, 1'b0, 1'b0);
      wait_until(k2 + 30);

      // Rewrite ch0 in the middle of its OFF phase.
      do_restart(r);
      for (int j = 21; j < 30; j++)
         exp_l(r + j, "pre_rewrite_off", 4'b0001, 4'b0000, 4'h0, 4'h0);
      wait_until(r + 29);
      do_write(0, 2'd0, M_BLINK, 8'd2, 8'd3, 1'b0, k);
      for (int j = 0; j < 11; j++)
         exp_l(k + j, "rewrite_mid_off", 4'b0001, 4'b0001, 4'h0, 4'h0);
      wait_until(k + 11);

      // ch0 and ch2 written 7 cycles apart, then aligned by restart.
      do_write(0, 2'd0, M_BLINK, 8'd3, 8'd2, 1'b0, k);
      wait_until(k + 6);
      do_write(0, 2'd2, M_BLINK, 8'd3, 8'd2, 1'b0, k2);
      wait_until(k2 + 13);
      do_restart(r);
      for (int j = 0; j < 100; j++)
         exp_l(r + j, "aligned_ch0_ch2", 4'b0101, ((j % 50) < 30) ? 4'b0101 : 4'b0000, 4'h0, 4'h0);
      wait_until(r + 100);

      // Asynchronous reset in the middle of a BLINK ON phase.
      do_restart(r);
      exp_l(r + 2, "pre_reset_on", 4'b0001, 4'b0001, 4'h0, 4'h0);
      wait_until(r + 3);
      rst = 1'b1;
      for (int j = 3; j < 6; j++)
         push(r + j, "reset_mid_blink", 4'hF, 4'h0, 4'hF, 4'h0, 3'h7, 3'h0, 1'b1, 1'b0);
      wait_until(r + 6);
      rst = 1'b0;
      for (int j = 6; j < 106; j++)
         push(r + j, "after_mid_reset", 4'hF, 4'h0, 4'hF, 4'h0, 3'h7, 3'h0, 1'b1, 1'b1);
      wait_until(r + 106);

      for (int j = 0; j < 50 && sb.size() > 0; j++) begin
         @(posedge clk);
         #2;
      end
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d expectations never compared, required 0", sb.size());
         n_cmp += sb.size();
         n_bad += sb.size();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
